axi_stream_writer_v3: RTL and testbench
=======================================

// Module: axi_stream_writer_v3
// PURPOSE
//  Producer-side AXI4-Stream master for the streamif s2mem path. It adds to the v2 pass-through:
//  - an internal FWFT FIFO, so upstream never sees a combinational TREADY path;
//  - forced TLAST after a parametrised maximum packet length;
//  - last-beat byte strobes;
//  - packet/beat status outputs.
//  It sits between the hardware-thread data source and the AXIS slave (s2mem DMA).
// PARAMETERS
//  C_M_AXIS_TDATA_WIDTH  32   data width; multiple of 8, 8..1024
//  C_FIFO_DEPTH          4    FIFO entries; power of two, >= 2
//  C_MAX_PKT_LEN         256  beats per packet before TLAST is forced; 0 = never force
//  C_CNT_WIDTH           16   width of pkt_count
// PORTS
//  M_AXIS_ACLK     in   1     clock; all logic on rising edge
//  M_AXIS_ARESETN  in   1     asynchronous active-low reset
//  data            in   W     input beat data (W = C_M_AXIS_TDATA_WIDTH)
//  data_keep       in   W/8   byte-valid mask; used only on last beat
//  data_valid      in   1     input beat valid
//  data_last       in   1     input beat ends packet
//  ready           out  1     FIFO can accept; beat accepted when data_valid & ready
//  M_AXIS_TVALID   out  1     AXIS valid
//  M_AXIS_TDATA    out  W     AXIS data
//  M_AXIS_TSTRB    out  W/8   AXIS strobe
//  M_AXIS_TLAST    out  1     AXIS last
//  M_AXIS_TREADY   in   1     AXIS ready
//  fifo_level      out  clog2(C_FIFO_DEPTH)+1  current occupancy
//  pkt_done        out  1     1-cycle pulse when a TLAST beat completes on AXIS
//  pkt_count       out  C_CNT_WIDTH  completed packets, wraps modulo 2^C_CNT_WIDTH
// BEHAVIOUR
//  Reset (async assert, sync deassert expected upstream):
//  - FIFO emptied; ready=0 while reset is asserted, 1 from the first clock after release.
//  - TVALID=0, TLAST=0, TDATA=0, TSTRB=0, pkt_done=0, pkt_count=0, fifo_level=0.
//  - Beat counter = 0. Mid-packet reset discards all buffered beats, with no TLAST emitted.
//  Ready: ready = (fifo_level < C_FIFO_DEPTH), registered-state only; no path from TREADY.
//  Push: on data_valid & ready, store {data, strb, last}. data_valid while ready=0 is ignored;
//   the source must hold data.
//  Stored last = data_last | (C_MAX_PKT_LEN != 0 && beat_cnt == C_MAX_PKT_LEN-1).
//  beat_cnt counts accepted beats; it clears on an accepted stored-last beat and otherwise increments.
//  Stored strb:
//  - all ones if stored last = 0;
//  - data_keep if stored last = 1 and data_keep != 0;
//  - all ones if data_keep == 0. A forced last uses the same rule with the beat's data_keep.
//  FWFT: FIFO head drives TDATA/TSTRB/TLAST; TVALID = (fifo_level != 0).
//   Write to an empty FIFO -> TVALID high the next cycle (1-cycle latency).
//  Pop: on TVALID & TREADY, the head advances.
//  TVALID/TDATA/TSTRB/TLAST stay stable while TVALID & !TREADY (AXIS rule).
//  Simultaneous push and pop: fifo_level unchanged; ordering is preserved.
//   Push when full is impossible; a pop when full raises ready next cycle.
//  Wrap-around: read/write pointers are clog2(DEPTH) bits and wrap naturally.
//   Full/empty are derived from fifo_level, not pointer equality.
//  pkt_done: registered; high the cycle after a TVALID & TREADY & TLAST handshake.
//   pkt_count increments in that same cycle.
//  Throughput: 1 beat/cycle sustained when TREADY=1 and data_valid=1.
// TESTING
//  1 Reset then 8 beats 0x1..0x8, last on beat 8, TREADY=1 -> TDATA 0x1..0x8 on consecutive cycles;
//    first TVALID 1 cycle after first accept; TLAST only on 0x8; pkt_done pulse; pkt_count=1.
//  2 TREADY=0, push 6 beats with DEPTH=4 -> ready falls after 4 accepts, fifo_level=4, TDATA=beat1 held;
//    TREADY=1 -> remaining 2 beats accepted, all 6 delivered in order.
//  3 C_MAX_PKT_LEN=4, 10 beats with data_last only on beat 10 -> TLAST on beats 4, 8 and 10;
//    pkt_count=3.
//  4 Last beat with data_keep=4'b0011 -> TSTRB=4'b0011 on that beat, 4'b1111 on others;
//    data_keep=0 on last -> TSTRB=4'b1111.
//  5 Random TREADY/data_valid (50%), 1000 beats -> scoreboard data/last match;
//    no TVALID drop without a handshake; TDATA stable while stalled.
//  6 Assert ARESETN=0 mid-packet with FIFO holding 3 beats -> TVALID=0 immediately (async);
//    after release fifo_level=0, beat_cnt restarts, next packet delivered correctly.

Source files
------------

// File: rtl/axi_stream_writer_v3.sv
// Producer-side AXI4-Stream master: FWFT FIFO in front of the AXIS port, forced TLAST
// after C_MAX_PKT_LEN beats, last-beat byte strobes and packet status counters.
module axi_stream_writer_v3 #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH         = 4,
  parameter int C_MAX_PKT_LEN        = 256,
  parameter int C_CNT_WIDTH          = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   data,
  input  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] data_keep,
  input  logic                              data_valid,
  input  logic                              data_last,
  output logic                              ready,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [$clog2(C_FIFO_DEPTH):0]     fifo_level,
  output logic                              pkt_done,
  output logic [C_CNT_WIDTH-1:0]            pkt_count
);

  localparam int W        = C_M_AXIS_TDATA_WIDTH;
  localparam int SW       = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int PW       = $clog2(C_FIFO_DEPTH);
  localparam int LW       = PW + 1;
  localparam int BCW      = (C_MAX_PKT_LEN > 1) ? $clog2(C_MAX_PKT_LEN) : 1;
  localparam bit FORCE_EN = (C_MAX_PKT_LEN != 0);

  logic [W-1:0]           mem_data_r [C_FIFO_DEPTH];
  logic [SW-1:0]          mem_strb_r [C_FIFO_DEPTH];
  logic                   mem_last_r [C_FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [LW-1:0]          level_r;
  logic                   rdy_en_r;
  logic [BCW-1:0]         beat_cnt_r;
  logic                   pkt_done_r;
  logic [C_CNT_WIDTH-1:0] pkt_count_r;

  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic          tvalid_s;
  logic          force_s;
  logic          wr_last_s;
  logic [SW-1:0] wr_strb_s;
  logic          head_last_s;

  // Handshake decode and the {strb, last} tag stored with each accepted beat.
  always_comb begin
    ready_s     = rdy_en_r && (level_r < LW'(C_FIFO_DEPTH));
    push_s      = data_valid && ready_s;
    tvalid_s    = (level_r != {LW{1'b0}});
    pop_s       = tvalid_s && M_AXIS_TREADY;
    head_last_s = mem_last_r[rd_ptr_r];
    force_s     = FORCE_EN && (beat_cnt_r == BCW'(C_MAX_PKT_LEN - 1));
    wr_last_s   = data_last || force_s;
    // data_keep only matters on a last beat; an all-zero mask would be meaningless, so send all bytes.
    if (wr_last_s && (data_keep != {SW{1'b0}})) begin
      wr_strb_s = data_keep;
    end else begin
      wr_strb_s = {SW{1'b1}};
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      for (int i = 0; i < C_FIFO_DEPTH; i++) begin
        mem_data_r[i] <= {W{1'b0}};
        mem_strb_r[i] <= {SW{1'b0}};
        mem_last_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= data;
      mem_strb_r[wr_ptr_r] <= wr_strb_s;
      mem_last_r[wr_ptr_r] <= wr_last_s;
    end
  end

  // Pointers wrap naturally; occupancy is tracked separately so full/empty never alias.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Beats accepted in the current packet; restarts after any stored last.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      beat_cnt_r <= {BCW{1'b0}};
    end else if (push_s) begin
      beat_cnt_r <= wr_last_s ? {BCW{1'b0}} : beat_cnt_r + BCW'(1);
    end
  end

  // Packet completion pulse and wrapping packet counter.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      pkt_done_r  <= 1'b0;
      pkt_count_r <= {C_CNT_WIDTH{1'b0}};
    end else begin
      pkt_done_r <= pop_s && head_last_s;
      if (pop_s && head_last_s) begin
        pkt_count_r <= pkt_count_r + C_CNT_WIDTH'(1);
      end
    end
  end

  assign ready         = ready_s;
  assign M_AXIS_TVALID = tvalid_s;
  assign M_AXIS_TDATA  = mem_data_r[rd_ptr_r];
  assign M_AXIS_TSTRB  = mem_strb_r[rd_ptr_r];
  assign M_AXIS_TLAST  = head_last_s;
  assign fifo_level    = level_r;
  assign pkt_done      = pkt_done_r;
  assign pkt_count     = pkt_count_r;

endmodule

// File: tb/tb_axi_stream_writer_v3.sv
// Self-checking bench: one instance with the default packet limit, one with a limit of 4,
// both fed the same stimulus and each checked against its own scoreboard.
module tb_axi_stream_writer_v3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic [3:0]  data_keep = 4'h0;
  logic        data_valid = 1'b0;
  logic        data_last = 1'b0;
  logic        tready = 1'b0;

  logic        ready, tvalid, tlast, pkt_done;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [2:0]  level;
  logic [15:0] pkt_count;
  logic        ready4, tvalid4, tlast4, pkt_done4;
  logic [31:0] tdata4;
  logic [3:0]  tstrb4;
  logic [2:0]  level4;
  logic [15:0] pkt_count4;

  axi_stream_writer_v3 #(.C_M_AXIS_TDATA_WIDTH(32), .C_FIFO_DEPTH(4),
                         .C_MAX_PKT_LEN(256), .C_CNT_WIDTH(16)) u_dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .data(data), .data_keep(data_keep),
    .data_valid(data_valid), .data_last(data_last), .ready(ready),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready), .fifo_level(level),
    .pkt_done(pkt_done), .pkt_count(pkt_count));

  axi_stream_writer_v3 #(.C_M_AXIS_TDATA_WIDTH(32), .C_FIFO_DEPTH(4),
                         .C_MAX_PKT_LEN(4), .C_CNT_WIDTH(16)) u_dut4 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .data(data), .data_keep(data_keep),
    .data_valid(data_valid), .data_last(data_last), .ready(ready4),
    .M_AXIS_TVALID(tvalid4), .M_AXIS_TDATA(tdata4), .M_AXIS_TSTRB(tstrb4),
    .M_AXIS_TLAST(tlast4), .M_AXIS_TREADY(tready), .fifo_level(level4),
    .pkt_done(pkt_done4), .pkt_count(pkt_count4));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    logic        v;
    logic        l;
    logic [3:0]  k;
    logic [31:0] d;
    logic        el;
    logic [3:0]  es;
    logic        el4;
    logic [3:0]  es4;
    logic        edn;
    logic        edn4;
  } vec_t;

  beat_t q_main[$];
  beat_t q4[$];
  vec_t  tbl[$];
  int    cnt4 = 0;
  int    total = 0;
  int    bad = 0;
  logic  prev_l = 1'b0;
  logic  prev_l4 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_row(input logic v, input logic l, input logic [3:0] k, input logic [31:0] d,
                         input logic el, input logic [3:0] es, input logic el4, input logic [3:0] es4);
    vec_t r;
    r.v = v; r.l = l; r.k = k; r.d = d;
    r.el = el; r.es = es; r.el4 = el4; r.es4 = es4;
    r.edn = prev_l; r.edn4 = prev_l4;
    prev_l  = v && el;
    prev_l4 = v && el4;
    tbl.push_back(r);
  endtask

  // One clock: scoreboard pops/pushes from pre-edge handshakes, then protocol checks.
  task automatic tick();
    logic hs, hs4, acc, acc4, stall, l0, l40, l4n, dl;
    logic [31:0] d0, d40, din;
    beat_t e;
    hs = tvalid && tready;  hs4 = tvalid4 && tready;
    d0 = tdata; l0 = tlast; d40 = tdata4; l40 = tlast4;
    stall = tvalid && !tready;
    acc = data_valid && ready; acc4 = data_valid && ready4;
    din = data; dl = data_last;
    l4n = dl || (cnt4 == 3);
    @(posedge clk); #1;
    if (hs) begin
      if (q_main.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_main: unexpected beat %0h, expected none", d0);
      end else begin
        e = q_main.pop_front();
        check("sb_data", d0, e.d);
        check("sb_last", l0, e.l);
      end
    end
    if (hs4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_4: unexpected beat %0h, expected none", d40);
      end else begin
        e = q4.pop_front();
        check("sb4_data", d40, e.d);
        check("sb4_last", l40, e.l);
      end
    end
    if (acc) q_main.push_back('{din, dl});
    if (acc4) begin
      q4.push_back('{din, l4n});
      cnt4 = l4n ? 0 : cnt4 + 1;
    end
    check("level", level, q_main.size());
    check("ready", ready, q_main.size() < 4);
    if (stall) begin
      check("stall_valid", tvalid, 1);
      check("stall_data", tdata, d0);
      check("stall_last", tlast, l0);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic [3:0] k);
    data_valid = v; data = d; data_last = l; data_keep = k;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stimulus tables: 8-beat packet, strobe rules, forced TLAST every 4 beats.
    for (int i = 1; i <= 8; i++)
      add_row(1'b1, i == 8, 4'hF, 32'(i), i == 8, 4'hF, (i == 4) || (i == 8), 4'hF);
    add_row(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0);
    add_row(1'b1, 1'b0, 4'h5, 32'h41, 1'b0, 4'hF, 1'b0, 4'hF);
    add_row(1'b1, 1'b1, 4'h3, 32'h42, 1'b1, 4'h3, 1'b1, 4'h3);
    add_row(1'b1, 1'b1, 4'h0, 32'h43, 1'b1, 4'hF, 1'b1, 4'hF);
    add_row(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 1; i <= 10; i++)
      add_row(1'b1, i == 10, 4'h6, 32'h50 + 32'(i), i == 10, (i == 10) ? 4'h6 : 4'hF,
              (i % 4 == 0) || (i == 10), ((i % 4 == 0) || (i == 10)) ? 4'h6 : 4'hF);
    add_row(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0);

    #12;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tstrb", tstrb, 0);
    check("rst_tlast", tlast, 0);
    check("rst_done", pkt_done, 0);
    check("rst_count", pkt_count, 0);
    check("rst_level", level, 0);
    check("rst_ready", ready, 0);
    #10 rst_n = 1'b1;
    #1 check("ready_pre_clk", ready, 0);
    tick();

    tready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].k);
      tick();
      check("t_valid", tvalid, tbl[i].v);
      check("t_done", pkt_done, tbl[i].edn);
      check("t_done4", pkt_done4, tbl[i].edn4);
      if (tbl[i].v) begin
        check("t_data", tdata, tbl[i].d);
        check("t_last", tlast, tbl[i].el);
        check("t_strb", tstrb, tbl[i].es);
        check("t_last4", tlast4, tbl[i].el4);
        check("t_strb4", tstrb4, tbl[i].es4);
      end
    end
    check("count_main", pkt_count, 4);
    check("count_4", pkt_count4, 7);

    // Back-pressure: fill to depth, hold, then drain.
    tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h20 + 32'(i), 1'b0, 4'hF);
      tick();
    end
    check("full_level", level, 4);
    check("full_ready", ready, 0);
    check("full_head", tdata, 32'h21);
    drive(1'b1, 32'h25, 1'b0, 4'hF);
    tick();
    tick();
    check("hold_level", level, 4);
    check("hold_head", tdata, 32'h21);
    tready = 1'b1;
    tick();
    check("pop_full_level", level, 3);
    check("pop_full_ready", ready, 1);
    check("pop_full_head", tdata, 32'h22);
    tick();
    drive(1'b1, 32'h26, 1'b1, 4'hF);
    tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (4) tick();
    check("drain_main", q_main.size(), 0);
    check("drain_4", q4.size(), 0);

    // Random valid/ready traffic against the scoreboards.
    begin
      int accepted = 0;
      int cycles = 0;
      logic took;
      while (accepted < 1000 && cycles < 20000) begin
        if (!data_valid || took) begin
          data_valid = 1'($urandom_range(0, 1));
          data = $urandom;
          data_last = ($urandom_range(0, 7) == 0);
          data_keep = 4'($urandom_range(0, 15));
        end
        tready = 1'($urandom_range(0, 1));
        took = data_valid && ready;
        if (took) accepted++;
        tick();
        cycles++;
      end
      check("rand_accepted", accepted, 1000);
      drive(1'b0, 32'h0, 1'b0, 4'h0);
      tready = 1'b1;
      repeat (6) tick();
      check("rand_drain_main", q_main.size(), 0);
      check("rand_drain_4", q4.size(), 0);
    end

    // Asynchronous reset with three buffered beats mid-packet.
    tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'h70 + 32'(i), 1'b0, 4'hF);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    check("pre_rst_level", level, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_level", level, 0);
    check("arst_tdata", tdata, 0);
    check("arst_tlast", tlast, 0);
    check("arst_ready", ready, 0);
    check("arst_tvalid4", tvalid4, 0);
    q_main.delete();
    q4.delete();
    cnt4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready", ready, 0);
    tick();
    tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'h60 + 32'(i), i == 5, 4'hF);
      tick();
      check("post_rst_data", tdata, 32'h60 + 32'(i));
      check("post_rst_last4", tlast4, (i == 4) || (i == 5));
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (3) tick();
    check("post_rst_count", pkt_count, 1);
    check("post_rst_count4", pkt_count4, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
